// File: rtl/square_rr_scheduler.sv
// Round-robin arbiter sharing one unsigned squaring datapath between NREQ requesters.
// Results land in a one-entry output stage tagged with the winning requester index.
module square_rr_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*DW-1:0]      res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 busy
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [2*DW-1:0]     res_data_q;
    logic [IDW-1:0]      res_id_q;

    logic                can_accept;
    logic                grant_found;
    logic [IDW-1:0]      grant_idx;
    logic [IDW-1:0]      cand;
    logic [NREQ-1:0]     grant;
    logic                transfer;
    logic [DW-1:0]       operand;
    logic [2*DW-1:0]     operand_ext;
    logic [2*DW-1:0]     square;

    assign can_accept = (state_q == StEmpty) || res_ready;

    // Scan from ptr upward, wrapping, and take the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        grant       = '0;
        if (can_accept) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = IDW'((32'(ptr_q) + k) % NREQ);
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Grants are suppressed combinationally while reset is held.
    assign req_ready = grant & {NREQ{rst_n}};
    assign transfer  = |(req_ready & req_valid);

    assign operand     = req_data[grant_idx*DW +: DW];
    assign operand_ext = {{DW{1'b0}}, operand};
    assign square      = operand_ext * operand_ext;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StEmpty: if (transfer) state_d = StFull;
            StFull:  if (res_ready && !transfer) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
        if (transfer) begin
            ptr_d = IDW'((32'(grant_idx) + 1) % NREQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            ptr_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (transfer) begin
                res_data_q <= square;
                res_id_q   <= grant_idx;
            end
        end
    end

    assign res_valid = (state_q == StFull);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = res_valid || (|req_valid);

endmodule

// File: tb/tb_square_rr_scheduler.sv
// Self-checking bench for square_rr_scheduler: directed vector tables, hand-written
// reset sequences and randomized traffic against a behavioural reference model.
module tb_square_rr_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 2;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [2*DW-1:0]      res_data;
    logic [IDW-1:0]       res_id;
    logic                 busy;

    int n_cmp;
    int n_fail;

    square_rr_scheduler #(
        .NREQ (NREQ),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;     // reset the DUT before applying this step
        logic [3:0] rv;
        logic [7:0] rd;
        logic       rdy;
        logic [3:0] exp_rr;
        logic       exp_v;
        logic [3:0] exp_d;
        logic [1:0] exp_id;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [3:0] rv, logic [7:0] rd, logic rdy,
                                logic [3:0] exp_rr, logic exp_v, logic [3:0] exp_d,
                                logic [1:0] exp_id);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rd = rd; v.rdy = rdy;
        v.exp_rr = exp_rr; v.exp_v = exp_v; v.exp_d = exp_d; v.exp_id = exp_id;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Leaves the bench at posedge+1 with the DUT idle and ptr at 0.
    task automatic do_reset();
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        if (v.rst) do_reset();
        tag = $sformatf("vec%0d", idx);
        req_valid = v.rv;
        req_data  = v.rd;
        res_ready = v.rdy;
        #3;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(v.exp_rr));
        @(posedge clk);
        #1;
        check({tag, ".res_valid"}, 32'(res_valid), 32'(v.exp_v));
        check({tag, ".res_data"}, 32'(res_data), 32'(v.exp_d));
        check({tag, ".res_id"}, 32'(res_id), 32'(v.exp_id));
    endtask

    // Reference model state: output stage contents and round-robin pointer.
    bit model_full;
    int model_data;
    int model_id;
    int model_ptr;

    task automatic random_run(input int cycles);
        int g;
        int op;
        logic [3:0] exp_rr;
        do_reset();
        model_full = 0; model_data = 0; model_id = 0; model_ptr = 0;
        for (int c = 0; c < cycles; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = 8'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            #3;
            g = -1;
            if (!model_full || res_ready) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(model_ptr + k) % NREQ])
                        g = (model_ptr + k) % NREQ;
                end
            end
            exp_rr = (g >= 0) ? 4'(1 << g) : 4'b0;
            check("rand.req_ready", 32'(req_ready), 32'(exp_rr));
            check("rand.busy", 32'(busy), 32'(model_full || (req_valid != 0)));
            @(posedge clk);
            if (g >= 0) begin
                op = (int'(req_data) >> (g * DW)) % (1 << DW);
                model_full = 1;
                model_data = op * op;
                model_id   = g;
                model_ptr  = (g + 1) % NREQ;
            end else if (model_full && res_ready) begin
                model_full = 0;
            end
            #1;
            check("rand.res_valid", 32'(res_valid), 32'(model_full));
            check("rand.res_data", 32'(res_data), 32'(model_data));
            check("rand.res_id", 32'(res_id), 32'(model_id));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        res_ready = 1'b0;

        // Reset then idle
        do_reset();
        #3;
        check("idle.res_valid", 32'(res_valid), 32'd0);
        check("idle.res_data", 32'(res_data), 32'd0);
        check("idle.res_id", 32'(res_id), 32'd0);
        check("idle.req_ready", 32'(req_ready), 32'd0);
        check("idle.busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Single requester sweep on req2: 0,1,2,3 -> 0,1,4,9
        tbl.push_back(mk(1, 4'b0100, 8'h00, 1, 4'b0100, 1, 4'd0, 2'd2));
        tbl.push_back(mk(0, 4'b0100, 8'h10, 1, 4'b0100, 1, 4'd1, 2'd2));
        tbl.push_back(mk(0, 4'b0100, 8'h20, 1, 4'b0100, 1, 4'd4, 2'd2));
        tbl.push_back(mk(0, 4'b0100, 8'h30, 1, 4'b0100, 1, 4'd9, 2'd2));
        tbl.push_back(mk(0, 4'b0000, 8'h00, 1, 4'b0000, 0, 4'd9, 2'd2));
        // Round-robin fairness: data 3,2,1,0 on req0..req3
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk(r == 0, 4'b1111, 8'h1B, 1, 4'b0001, 1, 4'd9, 2'd0));
            tbl.push_back(mk(0, 4'b1111, 8'h1B, 1, 4'b0010, 1, 4'd4, 2'd1));
            tbl.push_back(mk(0, 4'b1111, 8'h1B, 1, 4'b0100, 1, 4'd1, 2'd2));
            tbl.push_back(mk(0, 4'b1111, 8'h1B, 1, 4'b1000, 1, 4'd0, 2'd3));
        end
        // Backpressure: req1=3, req3=2
        tbl.push_back(mk(1, 4'b1010, 8'h8C, 0, 4'b0010, 1, 4'd9, 2'd1));
        tbl.push_back(mk(0, 4'b1010, 8'h8C, 0, 4'b0000, 1, 4'd9, 2'd1));
        tbl.push_back(mk(0, 4'b1010, 8'h8C, 0, 4'b0000, 1, 4'd9, 2'd1));
        tbl.push_back(mk(0, 4'b1010, 8'h8C, 0, 4'b0000, 1, 4'd9, 2'd1));
        tbl.push_back(mk(0, 4'b1010, 8'h8C, 1, 4'b1000, 1, 4'd4, 2'd3));
        tbl.push_back(mk(0, 4'b0000, 8'h00, 1, 4'b0000, 0, 4'd4, 2'd3));
        // Pointer wrap and skip after req3: req0=1, req2=3
        tbl.push_back(mk(0, 4'b0101, 8'h31, 1, 4'b0001, 1, 4'd1, 2'd0));
        tbl.push_back(mk(0, 4'b0101, 8'h31, 1, 4'b0100, 1, 4'd9, 2'd2));
        tbl.push_back(mk(0, 4'b0101, 8'h31, 1, 4'b0001, 1, 4'd1, 2'd0));
        tbl.push_back(mk(0, 4'b0000, 8'h00, 1, 4'b0000, 0, 4'd1, 2'd0));

        foreach (tbl[i]) run_vec(i, tbl[i]);

        // Reset mid-operation: fill via req1 (ptr moves to 2), then reset asynchronously
        do_reset();
        req_valid = 4'b0010;
        req_data  = 8'h0C;
        res_ready = 1'b0;
        #3;
        check("midrst.pre_rr", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        check("midrst.pre_valid", 32'(res_valid), 32'd1);
        check("midrst.pre_data", 32'(res_data), 32'd9);
        req_valid = 4'b1111;
        req_data  = 8'h03;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.valid", 32'(res_valid), 32'd0);
        check("midrst.data", 32'(res_data), 32'd0);
        check("midrst.id", 32'(res_id), 32'd0);
        check("midrst.rr", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst.post_rr", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("midrst.post_valid", 32'(res_valid), 32'd1);
        check("midrst.post_data", 32'(res_data), 32'd9);
        check("midrst.post_id", 32'(res_id), 32'd0);
        req_valid = '0;

        random_run(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/square_rr_scheduler.md
Name: square_rr_scheduler

Overview:
- Shares one unsigned squaring datapath (DW-bit N -> 2*DW-bit N^2) between NREQ requesters.
- Requesters present operands over valid/ready handshakes. A round-robin arbiter grants one per cycle.
- The squared result is registered into a one-entry output stage, tagged with the requester index, and drained over a valid/ready handshake.
- Sits between operand producers and a single shared consumer of square results.

Parameters:
- NREQ, 4, number of requesters (>=2).
- DW, 2, operand width in bits; result width is 2*DW.
- IDW, $clog2(NREQ), width of the requester-index tag (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  bit i: requester i presents an operand
- req_data  input  NREQ*DW  operand of requester i at bits [i*DW +: DW]
- req_ready  output  NREQ  bit i: requester i granted this cycle; one-hot or zero
- res_valid  output  1  output stage holds a result
- res_ready  input  1  consumer accepts the result
- res_data  output  2*DW  registered square of the granted operand
- res_id  output  IDW  index of the requester that produced res_data
- busy  output  1  res_valid OR any req_valid

Behaviour:
- Reset (rst_n low, asynchronous):
  - res_valid=0, res_data=0, res_id=0, round-robin pointer ptr=0.
  - req_ready is forced to all-zero while rst_n is low.
  - Any held result is discarded.
  - Operation resumes on the first rising clk edge after release.
- Output stage is a two-state FSM:
  - EMPTY (res_valid=0) and FULL (res_valid=1).
  - can_accept = EMPTY OR (FULL AND res_ready).
- Arbitration (combinational):
  - When can_accept, grant the first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready[i]=1 only for that i. Zero grants if no valid or not can_accept.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer occurs on a clk edge where req_valid[i] AND req_ready[i]. At that edge:
  - res_data <= req_data[i]^2, computed exactly in 2*DW unsigned bits with no truncation.
  - res_id <= i, res_valid <= 1, ptr <= (i+1) mod NREQ.
- Latency: result visible one cycle after the grant edge. Throughput is one result per cycle while res_ready is held high.
- FULL AND res_ready with no grant: res_valid <= 0. res_data and res_id hold their last values.
- FULL AND NOT res_ready: stage holds. res_data, res_id and res_valid are stable. No grants are issued (backpressure).
- Simultaneous drain and grant: the new result replaces the old one in the same edge, and res_valid stays 1.
- Pointer behaviour:
  - ptr changes only on a transfer.
  - A requester that drops req_valid before being granted gets nothing recorded.
- Operand data is sampled only at the transfer edge; it need not be stable otherwise.
- Boundary values (DW=2): 0->0 (4'b0000), 1->1, 2->4 (4'b0100), 3->9 (4'b1001).

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low 2 cycles, then high with no valids.
  - Required: res_valid=0, res_data=0, res_id=0, req_ready=0, busy=0.
- Single requester sweep:
  - Stimulus: req 2 presents 0,1,2,3 on consecutive cycles with res_ready=1.
  - Required: res_data 0,1,4,9 each one cycle after its grant, res_id=2, req_ready=4'b0100 every cycle.
- Round-robin fairness:
  - Stimulus: all four valid continuously with data 3,2,1,0 (req0..req3), res_ready=1.
  - Required: grant order 0,1,2,3,0,... and results 9,4,1,0 repeating, with res_id 0,1,2,3.
- Backpressure:
  - Stimulus: res_ready=0 for 3 cycles while req1 (data 3) and req3 (data 2) are valid.
  - Required: after the first grant (req1; res_data=9, res_id=1) the output holds and req_ready=0 for those 3 cycles.
  - Then res_ready=1: req3 is granted on the same edge the old result drains. Next cycle res_data=4, res_id=3, with no res_valid gap.
- Pointer wrap and skip:
  - Stimulus: after a grant to req3, only req0 and req2 are valid.
  - Required: req0 granted first, then req2.
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously while FULL (res_valid=1, res_data=9).
  - Required: res_valid, res_data and res_id clear immediately without a clock edge. ptr=0, so req0 wins first after release.
